// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle for ram_port_arbiter.
// The arbiter connects through the slave modport; whatever drives requests
// and models the RAM connects through the master modport.
interface ram_port_arbiter_if #(
  parameter int N_REQ       = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int BYTE_WIDTH  = 8,
  parameter int BATCH_WIDTH = 4
);
  localparam int DW = BYTE_WIDTH * BATCH_WIDTH;

  // Requester side
  logic [N_REQ-1:0]             req_valid_i;
  logic [N_REQ-1:0]             req_ready_o;
  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr_i;
  logic [N_REQ*DW-1:0]          req_wdata_i;
  logic [N_REQ*BATCH_WIDTH-1:0] req_byte_en_i;
  logic [N_REQ-1:0]             rsp_valid_o;
  logic [DW-1:0]                rsp_data_o;

  // RAM side
  logic [ADDR_WIDTH-1:0]        addr_o;
  logic [DW-1:0]                write_o;
  logic [BATCH_WIDTH-1:0]       byte_en_o;
  logic                         write_en_o;
  logic [DW-1:0]                data_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_byte_en_i, data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o,
           addr_o, write_o, byte_en_o, write_en_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_byte_en_i, data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o,
           addr_o, write_o, byte_en_o, write_en_o
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one byte-enabled RAM port between N_REQ
// requesters. The owner may keep the port for up to MAX_BURST consecutive
// beats while others wait; read data is routed back by a RD_LAT-deep
// {valid, id} shift register. The request-to-RAM path is combinational.
module ram_port_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int BYTE_WIDTH  = 8,
  parameter int BATCH_WIDTH = 4,
  parameter int MAX_BURST   = 4,
  parameter int RD_LAT      = 1
) (
  input logic               clk_i,
  input logic               rst_n_i,
  ram_port_arbiter_if.slave bus
);
  localparam int DW    = BYTE_WIDTH * BATCH_WIDTH;
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [PTR_W:0]   N_EXT     = (PTR_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);

  typedef struct packed {
    logic             vld;
    logic [PTR_W-1:0] id;
  } rd_stage_t;

  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic                   owner_vld_q, owner_vld_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  rd_stage_t              rd_pipe_q [RD_LAT];
  rd_stage_t              stage0_d;

  logic [N_REQ-1:0]       owner_mask_s;
  logic                   others_vld_s;
  logic                   hold_s;
  logic                   scan_vld_s;
  logic [PTR_W-1:0]       scan_idx_s;
  logic [PTR_W:0]         idx_ext_s;
  logic [PTR_W-1:0]       grant_s;
  logic                   grant_vld_s;
  logic                   xfer_s;
  logic [ADDR_WIDTH-1:0]  sel_addr_s;
  logic [DW-1:0]          sel_wdata_s;
  logic [BATCH_WIDTH-1:0] sel_be_s;

  // Grant selection: burst hold for the current owner, else round-robin scan from rr_ptr.
  always_comb begin
    owner_mask_s          = '0;
    owner_mask_s[owner_q] = 1'b1;
    others_vld_s = |(bus.req_valid_i & ~owner_mask_s);
    hold_s = owner_vld_q && bus.req_valid_i[owner_q] &&
             ((beat_cnt_q < BURST_MAX) || !others_vld_s);
    scan_vld_s = 1'b0;
    scan_idx_s = '0;
    idx_ext_s  = '0;
    // Scan from the far end so the candidate closest to rr_ptr wins last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_ext_s = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
      if (idx_ext_s >= N_EXT) begin
        idx_ext_s = idx_ext_s - N_EXT;
      end else begin
        idx_ext_s = idx_ext_s;
      end
      if (bus.req_valid_i[idx_ext_s[PTR_W-1:0]]) begin
        scan_vld_s = 1'b1;
        scan_idx_s = idx_ext_s[PTR_W-1:0];
      end else begin
        scan_vld_s = scan_vld_s;
      end
    end
    if (hold_s) begin
      grant_s = owner_q;
    end else begin
      grant_s = scan_idx_s;
    end
    grant_vld_s = hold_s || scan_vld_s;
    // Grants only go to valid requesters, so a grant is a transfer.
    xfer_s      = grant_vld_s && rst_n_i;
    sel_addr_s  = bus.req_addr_i[grant_s*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata_s = bus.req_wdata_i[grant_s*DW +: DW];
    sel_be_s    = bus.req_byte_en_i[grant_s*BATCH_WIDTH +: BATCH_WIDTH];
  end

  // Next-state for owner, burst counter, rr pointer, held address and read-tag entry.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    beat_cnt_d  = '0;
    addr_d      = addr_q;
    stage0_d    = '0;
    if (xfer_s) begin
      if (owner_vld_q && (grant_s == owner_q)) begin
        owner_vld_d = 1'b1;
        if (beat_cnt_q < BURST_MAX) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end else begin
        owner_d     = grant_s;
        owner_vld_d = 1'b1;
        beat_cnt_d  = CNT_W'(1);
      end
      if (grant_s == LAST_IDX) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_s + PTR_W'(1);
      end
      addr_d       = sel_addr_s;
      stage0_d.vld = (sel_be_s == '0);
      stage0_d.id  = grant_s;
    end else begin
      owner_vld_d = 1'b0;
      beat_cnt_d  = '0;
    end
  end

  // State registers and read-return shift register; reset discards in-flight reads.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      beat_cnt_q  <= '0;
      addr_q      <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        rd_pipe_q[k] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      owner_vld_q  <= owner_vld_d;
      beat_cnt_q   <= beat_cnt_d;
      addr_q       <= addr_d;
      rd_pipe_q[0] <= stage0_d;
      for (int k = 1; k < RD_LAT; k++) begin
        rd_pipe_q[k] <= rd_pipe_q[k-1];
      end
    end
  end

  // RAM port mux, requester accept and read-response routing; all zero under reset.
  always_comb begin
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.rsp_data_o  = '0;
    bus.addr_o      = '0;
    bus.write_o     = '0;
    bus.byte_en_o   = '0;
    if (rst_n_i) begin
      bus.rsp_data_o = bus.data_i;
      if (xfer_s) begin
        bus.req_ready_o[grant_s] = 1'b1;
        bus.addr_o               = sel_addr_s;
        bus.write_o              = sel_wdata_s;
        bus.byte_en_o            = sel_be_s;
      end else begin
        bus.addr_o = addr_q;
      end
      if (rd_pipe_q[RD_LAT-1].vld) begin
        bus.rsp_valid_o[rd_pipe_q[RD_LAT-1].id] = 1'b1;
      end else begin
        bus.rsp_valid_o = '0;
      end
    end else begin
      bus.rsp_data_o = '0;
      bus.addr_o     = '0;
    end
  end

  assign bus.write_en_o = |bus.byte_en_o;

endmodule
